// File: rtl/armv4_pkg.sv
// Shared ARMv4 register-file definitions: register index type, PC alias and the
// operand-fetch state encoding.
package armv4_pkg;

    typedef logic [3:0] reg_idx_t;

    localparam reg_idx_t    REG_PC         = 4'd15;
    localparam int unsigned PC_READ_OFFSET = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/operand_slot.sv
// One operand slot: holds the collected value and whether a register-file read
// is still owed to it.
module operand_slot #(
    parameter int unsigned DATA_SIZE = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_load_zero,
    input  logic                 i_load_pc,
    input  logic                 i_load_pend,
    input  logic                 i_load_rd,
    input  logic [DATA_SIZE-1:0] i_pc_val,
    input  logic [DATA_SIZE-1:0] i_rd_data,
    output logic [DATA_SIZE-1:0] o_value,
    output logic                 o_pend
);

    logic [DATA_SIZE-1:0] r_value;
    logic                 r_pend;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
            r_pend  <= 1'b0;
        end else if (i_clear || i_load_zero) begin
            r_value <= '0;
            r_pend  <= 1'b0;
        end else if (i_load_pc) begin
            r_value <= i_pc_val;
            r_pend  <= 1'b0;
        end else if (i_load_pend) begin
            r_value <= '0;
            r_pend  <= 1'b1;
        end else if (i_load_rd) begin
            r_value <= i_rd_data;
            r_pend  <= 1'b0;
        end
    end

    assign o_value = r_value;
    assign o_pend  = r_pend;

endmodule

// File: rtl/operand_fetch_unit.sv
// Collects up to three source operands (Rn, Rm, Rs) through one synchronous
// register-file read port; R15 is resolved locally as PC + offset.
module operand_fetch_unit
    import armv4_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned PC_OFFSET = PC_READ_OFFSET
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_req,
    output logic                 o_req_ready,
    input  logic                 i_use_n,
    input  logic                 i_use_m,
    input  logic                 i_use_s,
    input  logic [ADDR_SIZE-1:0] i_idx_n,
    input  logic [ADDR_SIZE-1:0] i_idx_m,
    input  logic [ADDR_SIZE-1:0] i_idx_s,
    input  logic [DATA_SIZE-1:0] i_pc_in,
    output logic                 o_rd_en,
    output logic [ADDR_SIZE-1:0] o_rd_addr,
    input  logic [DATA_SIZE-1:0] i_rd_data,
    output logic                 o_op_valid,
    input  logic                 i_op_ready,
    output logic [DATA_SIZE-1:0] o_op_a,
    output logic [DATA_SIZE-1:0] o_op_b,
    output logic [DATA_SIZE-1:0] o_op_c
);

    fetch_state_t              r_state, w_state_d;
    logic [2:0][ADDR_SIZE-1:0] r_idx, w_idx;
    logic [2:0]                r_issue, w_use, w_is_pc, w_pend;
    logic [2:0]                w_ld_zero, w_ld_pc, w_ld_pend, w_ld_rd;
    logic [2:0]                w_iss_mask, w_cap_mask;
    logic [1:0]                w_iss_sel, r_cap_sel;
    logic                      r_cap_vld, r_op_valid;
    logic                      w_iss_vld, w_accept, w_can_take, w_done;
    logic [ADDR_SIZE-1:0]      w_iss_addr;
    logic [DATA_SIZE-1:0]      w_pc_val;
    logic [DATA_SIZE-1:0]      w_val [3];

    assign w_use    = {i_use_s, i_use_m, i_use_n};
    assign w_idx    = {i_idx_s, i_idx_m, i_idx_n};
    assign w_pc_val = i_pc_in + DATA_SIZE'(PC_OFFSET);

    assign w_can_take  = (r_state == IDLE) || ((r_state == HOLD) && i_op_ready);
    assign w_accept    = i_req && w_can_take && !i_flush;
    assign o_req_ready = w_can_take;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_is_pc[i]   = (w_idx[i] == ADDR_SIZE'(REG_PC));
            w_ld_zero[i] = w_accept && !w_use[i];
            w_ld_pc[i]   = w_accept && w_use[i] && w_is_pc[i];
            w_ld_pend[i] = w_accept && w_use[i] && !w_is_pc[i];
            w_ld_rd[i]   = r_cap_vld && (r_cap_sel == 2'(i)) && !i_flush;
        end
    end

    // Issue order N, M, S: lowest outstanding slot goes first.
    always_comb begin
        w_iss_sel = 2'd2;
        if (r_issue[0]) begin
            w_iss_sel = 2'd0;
        end else if (r_issue[1]) begin
            w_iss_sel = 2'd1;
        end
        case (w_iss_sel)
            2'd0:    w_iss_addr = r_idx[0];
            2'd1:    w_iss_addr = r_idx[1];
            default: w_iss_addr = r_idx[2];
        endcase
    end

    assign w_iss_vld  = (r_state == FETCH) && (r_issue != 3'b000) && !i_flush;
    assign w_iss_mask = 3'b001 << w_iss_sel;
    assign w_cap_mask = r_cap_vld ? (3'b001 << r_cap_sel) : 3'b000;
    assign w_done     = (w_pend & ~w_cap_mask) == 3'b000;
    assign o_rd_en    = w_iss_vld;
    assign o_rd_addr  = w_iss_vld ? w_iss_addr : '0;

    // Every request passes through FETCH, so latency is k+1 even when k = 0.
    always_comb begin
        w_state_d = r_state;
        if (i_flush) begin
            w_state_d = IDLE;
        end else if (w_accept) begin
            w_state_d = FETCH;
        end else begin
            case (r_state)
                FETCH:   if (w_done) w_state_d = HOLD;
                HOLD:    if (i_op_ready) w_state_d = IDLE;
                default: w_state_d = r_state;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_op_valid <= 1'b0;
            r_issue    <= '0;
            r_idx      <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_sel  <= 2'd0;
        end else begin
            r_state    <= w_state_d;
            r_op_valid <= (w_state_d == HOLD);
            r_cap_vld  <= w_iss_vld;
            r_cap_sel  <= w_iss_sel;
            if (i_flush) begin
                r_issue <= '0;
            end else if (w_accept) begin
                r_issue <= w_ld_pend;
                r_idx   <= w_idx;
            end else if (w_iss_vld) begin
                r_issue <= r_issue & ~w_iss_mask;
            end
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_slot
        operand_slot #(
            .DATA_SIZE(DATA_SIZE)
        ) u_slot (
            .i_clk      (i_clk),
            .i_rst_n    (i_rst_n),
            .i_clear    (i_flush),
            .i_load_zero(w_ld_zero[g]),
            .i_load_pc  (w_ld_pc[g]),
            .i_load_pend(w_ld_pend[g]),
            .i_load_rd  (w_ld_rd[g]),
            .i_pc_val   (w_pc_val),
            .i_rd_data  (i_rd_data),
            .o_value    (w_val[g]),
            .o_pend     (w_pend[g])
        );
    end

    assign o_op_valid = r_op_valid;
    assign o_op_a     = w_val[0];
    assign o_op_b     = w_val[1];
    assign o_op_c     = w_val[2];

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: directed scenarios plus randomized requests checked
// against a register-file array model and per-request expected operands/reads.
module tb_operand_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        req;
    logic        req_ready;
    logic        use_n, use_m, use_s;
    logic [3:0]  idx_n, idx_m, idx_s;
    logic [31:0] pc_in;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        op_valid;
    logic        op_ready;
    logic [31:0] op_a, op_b, op_c;

    logic [31:0] regs [16];
    logic [31:0] exp_ops [3];
    int          exp_reads [$];
    int          n_checks;
    int          n_fail;

    operand_fetch_unit u_dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_flush    (flush),
        .i_req      (req),
        .o_req_ready(req_ready),
        .i_use_n    (use_n),
        .i_use_m    (use_m),
        .i_use_s    (use_s),
        .i_idx_n    (idx_n),
        .i_idx_m    (idx_m),
        .i_idx_s    (idx_s),
        .i_pc_in    (pc_in),
        .o_rd_en    (rd_en),
        .o_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .o_op_valid (op_valid),
        .i_op_ready (op_ready),
        .o_op_a     (op_a),
        .o_op_b     (op_b),
        .o_op_c     (op_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous register file; garbage on the bus when no read was issued.
    always @(posedge clk) rd_data <= rd_en ? regs[rd_addr] : $urandom();

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic start_req(input logic [2:0] u, input logic [3:0] xn, input logic [3:0] xm,
                             input logic [3:0] xs, input logic [31:0] pc, input bit consume);
        logic [3:0] ix [3];
        ix[0] = xn;
        ix[1] = xm;
        ix[2] = xs;
        exp_reads.delete();
        for (int i = 0; i < 3; i++) begin
            if (!u[i]) exp_ops[i] = 32'd0;
            else if (ix[i] == 4'd15) exp_ops[i] = pc + 32'd8;
            else begin
                exp_ops[i] = regs[ix[i]];
                exp_reads.push_back(int'(ix[i]));
            end
        end
        {use_s, use_m, use_n} = u;
        idx_n    = xn;
        idx_m    = xm;
        idx_s    = xs;
        pc_in    = pc;
        req      = 1'b1;
        op_ready = consume;
        #1;
        check_eq("req_ready_at_accept", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req      = 1'b0;
        op_ready = 1'b0;
        {use_s, use_m, use_n} = 3'($urandom());
        idx_n = 4'($urandom());
        pc_in = $urandom();
    endtask

    task automatic collect();
        int c;
        int n_rd;
        c    = 0;
        n_rd = 0;
        while (!op_valid && c < 10) begin
            if (rd_en) begin
                if (n_rd < exp_reads.size()) begin
                    check_eq("rd_addr", {28'd0, rd_addr}, exp_reads[n_rd]);
                    check_eq("rd_cycle", c, n_rd);
                end
                n_rd++;
            end
            @(negedge clk);
            c++;
        end
        check_eq("read_count", n_rd, exp_reads.size());
        check_eq("latency", c, exp_reads.size() + 1);
        check_eq("op_a", op_a, exp_ops[0]);
        check_eq("op_b", op_b, exp_ops[1]);
        check_eq("op_c", op_c, exp_ops[2]);
    endtask

    task automatic hold_check(input int cycles);
        op_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            check_eq("hold_valid", {31'd0, op_valid}, 32'd1);
            check_eq("hold_op_a", op_a, exp_ops[0]);
            check_eq("hold_op_b", op_b, exp_ops[1]);
            check_eq("hold_op_c", op_c, exp_ops[2]);
            check_eq("hold_no_read", {31'd0, rd_en}, 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic consume(input int stall);
        hold_check(stall);
        op_ready = 1'b1;
        #1;
        check_eq("ready_follows_op_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        op_ready = 1'b0;
        check_eq("valid_drop_after_consume", {31'd0, op_valid}, 32'd0);
        check_eq("idle_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [2:0]  u;
        logic [3:0]  x [3];
        int          n_rd;
        int          n_v;
        bit          pending;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        flush    = 1'b0;
        req      = 1'b0;
        op_ready = 1'b0;
        {use_s, use_m, use_n} = 3'b000;
        idx_n = 4'd0;
        idx_m = 4'd0;
        idx_s = 4'd0;
        pc_in = 32'd0;
        for (int r = 0; r < 16; r++) regs[r] = $urandom();

        repeat (2) @(negedge clk);
        check_eq("rst_op_valid", {31'd0, op_valid}, 32'd0);
        check_eq("rst_rd_en", {31'd0, rd_en}, 32'd0);
        check_eq("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
        check_eq("rst_op_a", op_a, 32'd0);
        check_eq("rst_op_b", op_b, 32'd0);
        check_eq("rst_op_c", op_c, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("rst_release_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);

        // Reset asserted during the second read of a three-read request.
        start_req(3'b111, 4'd1, 4'd2, 4'd3, 32'h100, 1'b0);
        check_eq("mid_first_read", {31'd0, rd_en}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_rd_en", {31'd0, rd_en}, 32'd0);
        check_eq("mid_rst_rd_addr", {28'd0, rd_addr}, 32'd0);
        check_eq("mid_rst_valid", {31'd0, op_valid}, 32'd0);
        check_eq("mid_rst_op_a", op_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        n_rd = 0;
        n_v  = 0;
        repeat (5) begin
            @(negedge clk);
            if (rd_en) n_rd++;
            if (op_valid) n_v++;
        end
        check_eq("post_rst_reads", n_rd, 0);
        check_eq("post_rst_valid", n_v, 0);

        // Three distinct register reads.
        regs[1] = 32'h11;
        regs[2] = 32'h22;
        regs[3] = 32'h33;
        start_req(3'b111, 4'd1, 4'd2, 4'd3, 32'h200, 1'b0);
        collect();
        consume(0);

        // R15 source with PC wrap-around.
        start_req(3'b001, 4'd15, 4'd4, 4'd6, 32'hFFFF_FFFC, 1'b0);
        collect();
        consume(1);

        // Same register in two slots.
        regs[5] = 32'hDEAD_BEEF;
        start_req(3'b011, 4'd5, 4'd5, 4'd0, 32'h300, 1'b0);
        collect();
        consume(0);

        // Stall in HOLD, then consume and accept on the same edge.
        start_req(3'b001, 4'd15, 4'd0, 4'd0, 32'h400, 1'b0);
        collect();
        hold_check(3);
        start_req(3'b111, 4'd7, 4'd8, 4'd9, 32'h500, 1'b1);
        collect();
        consume(0);

        // Flush the cycle after the first read; a REQ in the flush cycle is ignored.
        start_req(3'b111, 4'd4, 4'd6, 4'd7, 32'h600, 1'b0);
        check_eq("flush_first_read", {31'd0, rd_en}, 32'd1);
        @(negedge clk);
        flush = 1'b1;
        req   = 1'b1;
        use_n = 1'b1;
        idx_n = 4'd9;
        @(negedge clk);
        flush = 1'b0;
        req   = 1'b0;
        use_n = 1'b0;
        check_eq("flush_op_a_cleared", op_a, 32'd0);
        check_eq("flush_idle_ready", {31'd0, req_ready}, 32'd1);
        n_rd = 0;
        n_v  = 0;
        repeat (8) begin
            if (rd_en) n_rd++;
            if (op_valid) n_v++;
            @(negedge clk);
        end
        check_eq("flush_no_reads", n_rd, 0);
        check_eq("flush_no_valid", n_v, 0);

        // Randomized requests, with random stalls and back-to-back accepts.
        pending = 1'b0;
        for (int it = 0; it < 60; it++) begin
            u = 3'($urandom());
            for (int i = 0; i < 3; i++)
                x[i] = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            for (int r = 0; r < 15; r++) regs[r] = $urandom();
            if (pending) begin
                if ($urandom_range(0, 2) == 0) begin
                    consume(int'($urandom_range(0, 3)));
                    start_req(u, x[0], x[1], x[2], $urandom(), 1'b0);
                end else begin
                    hold_check(int'($urandom_range(0, 3)));
                    start_req(u, x[0], x[1], x[2], $urandom(), 1'b1);
                end
            end else begin
                start_req(u, x[0], x[1], x[2], $urandom(), 1'b0);
            end
            collect();
            pending = 1'b1;
        end
        consume(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
